// File: rtl/crc32_pkg.sv
// crc32_pkg: Ethernet CRC32 constants, sequencer state type and the 8-bit next-state function
package crc32_pkg;
  // Reflected form of 0x04C11DB7, since bytes go out LSB first
  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
  typedef enum logic [1:0] {IDLE, RUN, OPEN, FIN} state_t;
  function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/crc32_d16_step.sv
// crc32_d16_step: combinational CRC32 next-state over 16 data bits, low byte first
module crc32_d16_step import crc32_pkg::*; (
  input  logic [15:0] data_in,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ {16'd0, data_in};
    for (int i = 0; i < 16; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ CRC_POLY : crc_out >> 1;
  end
endmodule

// File: rtl/crc32_fcs_seq.sv
// crc32_fcs_seq: slices framed beats into 16/8-bit CRC32 steps and emits the inverted FCS.
// Optional CRC_CHECK_EN adds fcs_ok, the RX residue check registered with fcs_valid.
module crc32_fcs_seq import crc32_pkg::*; #(
  parameter int DATA_W = 64,
  parameter logic [31:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [31:0] XOR_OUT = 32'hFFFF_FFFF,
  localparam int SLICES = DATA_W / 16,
  localparam int BW = $clog2(DATA_W / 8) + 1,
  localparam int IW = $clog2(SLICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [BW-1:0]     in_bytes,
  output logic              fcs_valid,
  output logic [31:0]       fcs_data,
  output logic              busy,
  output logic              err_sop
`ifdef CRC_CHECK_EN
  ,
  output logic              fcs_ok
`endif
);
  state_t state_q, state_d;
  logic [31:0] crc_q, crc_d, fcs_q, fcs_d, c16, step;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IW-1:0] idx_q, idx_d, lst_q, lst_d;
  logic eop_q, eop_d, odd_q, odd_d, err_q, err_d, acc, last;
  logic [BW-1:0] nb;
  logic [15:0] slice;
`ifdef CRC_CHECK_EN
  logic ok_q, ok_d;
  logic [31:0] rev;
  assign fcs_ok = ok_q;
`endif
  crc32_d16_step u_step (.data_in(slice), .crc_in(crc_q), .crc_out(c16));
  always_comb begin
    nb = in_bytes == '0 ? BW'(DATA_W / 8) : in_bytes;
    slice = 16'(data_q >> {idx_q, 4'd0});
    last = idx_q == lst_q;
    step = eop_q && odd_q && last ? crc32_step8(crc_q, slice[7:0]) : c16;
    acc = in_valid && in_ready;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      crc_q <= CRC_INIT;
      idx_q <= '0;
      lst_q <= '0;
      data_q <= '0;
      eop_q <= 1'b0;
      odd_q <= 1'b0;
      fcs_q <= '0;
      err_q <= 1'b0;
`ifdef CRC_CHECK_EN
      ok_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      idx_q <= idx_d;
      lst_q <= lst_d;
      data_q <= data_d;
      eop_q <= eop_d;
      odd_q <= odd_d;
      fcs_q <= fcs_d;
      err_q <= err_d;
`ifdef CRC_CHECK_EN
      ok_q <= ok_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    crc_d = crc_q;
    idx_d = idx_q;
    fcs_d = fcs_q;
    err_d = 1'b0;
    data_d = acc ? in_data : data_q;
    eop_d = acc ? in_eop : eop_q;
    odd_d = acc ? in_eop && nb[0] : odd_q;
    lst_d = !acc ? lst_q : in_eop ? IW'((nb - 1'b1) >> 1) : IW'(SLICES - 1);
`ifdef CRC_CHECK_EN
    rev = {<<{step}};
    ok_d = ok_q;
`endif
    if (acc) idx_d = '0;
    case (state_q)
      RUN: begin
        crc_d = step;
        if (!last) idx_d = idx_q + 1'b1;
        else if (eop_q) begin
          state_d = FIN;
          fcs_d = step ^ XOR_OUT;
`ifdef CRC_CHECK_EN
          ok_d = rev == CRC_RESIDUE;
`endif
        end else if (!acc) state_d = OPEN;
        else if (in_sop) begin
          err_d = 1'b1;
          crc_d = CRC_INIT;
        end
      end
      OPEN: begin
        state_d = acc ? RUN : OPEN;
        err_d = acc && in_sop;
        crc_d = acc && in_sop ? CRC_INIT : crc_q;
      end
      default: begin
        state_d = acc && in_sop ? RUN : IDLE;
        crc_d = acc && in_sop ? CRC_INIT : crc_q;
        err_d = acc && !in_sop;
      end
    endcase
  end
  always_comb begin
    in_ready = state_q == RUN ? last && !eop_q : 1'b1;
    busy = state_q != IDLE;
    fcs_valid = state_q == FIN;
    fcs_data = fcs_q;
    err_sop = err_q;
  end
endmodule

// File: tb/tb_crc32_fcs_seq.sv
// tb_crc32_fcs_seq: table-driven and randomized checks of crc32_fcs_seq against a bit-serial CRC model
module tb_crc32_fcs_seq;
  typedef logic [7:0] bq_t[$];
  typedef struct { int n; int lat; int rdy; } st_t;
  typedef struct { string s; logic [31:0] fcs; } vec_t;
  logic clk = 0, rst = 0, in_valid = 0, in_sop = 0, in_eop = 0;
  logic [63:0] in_data = '0;
  logic [3:0] in_bytes = '0;
  logic in_ready, fcs_valid, busy, err_sop;
  logic [31:0] fcs_data;
  int tests = 0, fails = 0, errs = 0;
  logic [31:0] obs[$];
`ifdef CRC_CHECK_EN
  logic fcs_ok;
  logic ok_q[$];
  logic last_ok;
`endif
  crc32_fcs_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_bytes(in_bytes), .fcs_valid(fcs_valid),
    .fcs_data(fcs_data), .busy(busy), .err_sop(err_sop)
`ifdef CRC_CHECK_EN
    , .fcs_ok(fcs_ok)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (fcs_valid) begin
      obs.push_back(fcs_data);
`ifdef CRC_CHECK_EN
      ok_q.push_back(fcs_ok);
`endif
    end
    if (err_sop) errs++;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [31:0] crc_ref(input bq_t q);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[k])
      for (int b = 0; b < 8; b++) c = (c >> 1) ^ ((c[0] ^ q[k][b]) ? 32'hEDB8_8320 : 32'h0);
    return ~c;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out", nm);
  endtask
  task automatic clear_obs();
    obs.delete();
`ifdef CRC_CHECK_EN
    ok_q.delete();
`endif
  endtask
  task automatic wait_fcs(input string nm, input logic [31:0] exp);
    int t = 0;
    while (obs.size() == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (obs.size() == 0) timeout(nm);
    else begin
      check(nm, obs.pop_front(), exp);
`ifdef CRC_CHECK_EN
      last_ok = ok_q.pop_front();
`endif
    end
  endtask
  task automatic put_beat(input bq_t q, input int b, input bit zf);
    int n = q.size();
    int lb = (n + 7) / 8 - 1;
    int r = n - 8 * b;
    in_data = '0;
    for (int k = 0; k < 8; k++) if (8 * b + k < n) in_data[8 * k +: 8] = q[8 * b + k];
    in_sop = b == 0;
    in_eop = b == lb;
    in_bytes = b != lb ? 4'($urandom_range(0, 8)) : (r == 8 && zf) ? 4'd0 : 4'(r);
  endtask
  task automatic send_frame(input bq_t q, input bit gaps);
    int nb = (q.size() + 7) / 8;
    int g;
    for (int b = 0; b < nb; b++) begin
      put_beat(q, b, 1'($urandom_range(0, 1)));
      in_valid = 1;
      g = 0;
      while (!in_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g >= 100) timeout("send_ready");
      @(negedge clk);
      in_valid = 0;
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
  endtask
  task automatic stream(input bq_t q, output int lat, output int rdy);
    int nb = (q.size() + 7) / 8;
    int b = 0;
    logic a;
    lat = 0;
    rdy = 0;
    put_beat(q, 0, 1'b1);
    in_valid = 1;
    for (int n = 1; n <= 100 && lat == 0; n++) begin
      a = in_ready && in_valid;
      @(negedge clk);
      if (a) begin
        b++;
        if (b < nb) put_beat(q, b, 1'b1);
        else in_valid = 0;
      end
      if (fcs_valid) lat = n;
      else if (in_ready) rdy++;
    end
    in_valid = 0;
  endtask
  function automatic bq_t rnd_bytes(input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
    return q;
  endfunction
  function automatic bq_t str_bytes(input string s);
    bq_t q;
    for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
    return q;
  endfunction
  initial begin
    st_t stab[6];
    vec_t vt[6];
    bq_t q, a, c;
    logic [31:0] exp_q[$];
    logic [31:0] f;
    int lat, rdy, e0, t;
    stab[0] = '{2, 2, 0};
    stab[1] = '{3, 3, 0};
    stab[2] = '{8, 5, 0};
    stab[3] = '{9, 6, 1};
    stab[4] = '{17, 10, 2};
    stab[5] = '{64, 33, 7};
    vt[0].s = "123456789";  vt[0].fcs = 32'hCBF4_3926;
    vt[1].s = "a";          vt[1].fcs = 32'hE8B7_BE43;
    vt[2].s = "abc";        vt[2].fcs = 32'h3524_41C2;
    vt[3].s = "message digest"; vt[3].fcs = 32'h2015_9D7F;
    vt[4].s = "abcdefghijklmnopqrstuvwxyz"; vt[4].fcs = 32'h4C27_50BD;
    vt[5].s = "The quick brown fox jumps over the lazy dog"; vt[5].fcs = 32'h414F_A339;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fcs_valid", 32'(fcs_valid), 32'd0);
    check("rst_fcs_data", fcs_data, 32'd0);
    check("rst_err_sop", 32'(err_sop), 32'd0);
    rst = 1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      q.delete();
      for (int k = 0; k < stab[i].n; k++) q.push_back(8'(k + 1));
      clear_obs();
      stream(q, lat, rdy);
      if (lat == 0) timeout($sformatf("stream%0d_fcs", stab[i].n));
      check($sformatf("stream%0d_latency", stab[i].n), 32'(lat), 32'(stab[i].lat));
      check($sformatf("stream%0d_ready_count", stab[i].n), 32'(rdy), 32'(stab[i].rdy));
      wait_fcs($sformatf("stream%0d_fcs", stab[i].n), crc_ref(q));
      repeat (2) @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      clear_obs();
      send_frame(str_bytes(vt[i].s), 1'b1);
      wait_fcs($sformatf("known_vec%0d", i), vt[i].fcs);
    end
    repeat (3) @(negedge clk);
    clear_obs();
    e0 = errs;
    in_data = 64'h1234;
    in_sop = 0;
    in_eop = 1;
    in_bytes = 2;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (10) @(negedge clk);
    check("idle_nosop_err", 32'(errs - e0), 32'd1);
    check("idle_nosop_no_fcs", 32'(obs.size()), 32'd0);
    check("idle_nosop_busy", 32'(busy), 32'd0);
    a = rnd_bytes(16);
    c = rnd_bytes(13);
    put_beat(a, 0, 1'b0);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (8) @(negedge clk);
    check("open_busy", 32'(busy), 32'd1);
    check("open_ready", 32'(in_ready), 32'd1);
    e0 = errs;
    send_frame(c, 1'b0);
    wait_fcs("open_sop_new_fcs", crc_ref(c));
    check("open_sop_err", 32'(errs - e0), 32'd1);
    check("open_sop_single_fcs", 32'(obs.size()), 32'd0);
    repeat (2) @(negedge clk);
    put_beat(a, 0, 1'b0);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    #2 rst = 0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_fcs_valid", 32'(fcs_valid), 32'd0);
    check("midrst_fcs_data", fcs_data, 32'd0);
    check("midrst_err_sop", 32'(err_sop), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1;
    repeat (8) @(negedge clk);
    check("midrst_no_fcs", 32'(obs.size()), 32'd0);
    send_frame(c, 1'b1);
    wait_fcs("midrst_next_fcs", crc_ref(c));
    clear_obs();
    for (int i = 0; i < 30; i++) begin
      q = rnd_bytes($urandom_range(1, 40));
      exp_q.push_back(crc_ref(q));
      send_frame(q, 1'b1);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    t = 0;
    while (obs.size() < exp_q.size() && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("rand_fcs_count", 32'(obs.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) if (i < obs.size()) check($sformatf("rand_fcs%0d", i), obs[i], exp_q[i]);
`ifdef CRC_CHECK_EN
    clear_obs();
    q = rnd_bytes(21);
    f = crc_ref(q);
    q.push_back(f[7:0]);
    q.push_back(f[15:8]);
    q.push_back(f[23:16]);
    q.push_back(f[31:24]);
    send_frame(q, 1'b1);
    wait_fcs("chk_good_fcs", crc_ref(q));
    check("chk_good_ok", 32'(last_ok), 32'd1);
    q[3] = q[3] ^ 8'h10;
    send_frame(q, 1'b1);
    wait_fcs("chk_bad_fcs", crc_ref(q));
    check("chk_bad_ok", 32'(last_ok), 32'd0);
`endif
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/crc32_fcs_seq.md
Name: crc32_fcs_seq

Overview:
Sequencer that feeds a framed 64-bit stream into a 16-bit CRC32 next-state engine. It uses the Ethernet FCS polynomial with init all-ones. It slices each beat into 16-bit steps, handles an odd trailing byte with an 8-bit step, and emits the final inverted FCS. It sits between the MAC TX/RX datapath and FCS insert/check logic, one frame at a time.

Parameters:
DATA_W, 64, input beat width; must be 32 or 64. Derived localparam SLICES = DATA_W/16.
CRC_INIT, 32'hFFFF_FFFF, value the CRC register is loaded with on frame start.
XOR_OUT, 32'hFFFF_FFFF, value XORed onto the CRC register to form fcs_data.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  beat valid.
in_ready  out  1  beat accepted when in_valid & in_ready.
in_data  in  DATA_W  beat; byte k = in_data[8k+7:8k]; byte 0 is first on the wire.
in_sop  in  1  first beat of frame.
in_eop  in  1  last beat of frame.
in_bytes  in  $clog2(DATA_W/8)+1  valid bytes on eop beat; 0 means full beat; ignored when in_eop=0.
fcs_valid  out  1  one-cycle pulse; fcs_data is valid.
fcs_data  out  32  ~crc (crc ^ XOR_OUT); held until the next fcs_valid.
busy  out  1  a frame is open (state != IDLE).
err_sop  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; crc = CRC_INIT; slice index = 0.
  - fcs_valid = 0, fcs_data = 0, busy = 0, err_sop = 0.
  - in_ready is combinational from state, so it is 1 in IDLE.
  - Reset mid-frame discards the frame; no fcs_valid is produced.
- Beat register: an accepted beat is captured with its eop flag and slice count.
  - Slice count = SLICES for a non-eop beat.
  - Slice count = ceil(B/2) for an eop beat, where B = in_bytes (0 is treated as DATA_W/8).
  - The last slice is an 8-bit step on its low byte if B is odd.
- FSM:
  - IDLE, in_ready=1:
    - Accept with in_sop: crc <= CRC_INIT, go to RUN.
    - Accept without in_sop: beat dropped, err_sop pulses, stay IDLE.
  - RUN: one slice per cycle, slice i = in_data[16i+15:16i]; crc <= step(crc, slice).
    - in_ready=1 only on the final slice of a non-eop beat. An accept there loads the next beat, index = 0, stay RUN (no bubble). No accept: go to OPEN.
    - Final slice of an eop beat: go to FIN.
  - OPEN, in_ready=1: accept goes to RUN.
    - If in_sop is set on that accept, the open frame is abandoned: err_sop pulses and crc <= CRC_INIT.
  - FIN: fcs_valid=1, fcs_data = crc ^ XOR_OUT, in_ready=1.
    - Accept with sop: crc <= CRC_INIT, go to RUN (back-to-back frames).
    - Otherwise go to IDLE; an accept without sop follows the IDLE rule.
- in_sop & in_eop on the same beat is a legal single-beat frame.
- Throughput: one beat per SLICES cycles.
- Latency: fcs_valid in the cycle after the last slice.

Optional Feature:
CRC_CHECK_EN:
- When defined, adds output fcs_ok (1 bit), registered and valid with fcs_valid.
- fcs_ok = 1 iff the un-inverted crc equals package constant CRC_RESIDUE (32'hC704_DD7B) after the frame, which includes its received FCS. Used on the RX path.
- fcs_ok resets to 0.
- When undefined, the port and compare logic are absent; all other behaviour is identical.

Decomposition:
- Package crc32_pkg holds:
  - CRC_POLY, CRC_INIT_DEF, CRC_RESIDUE.
  - State enum (IDLE/RUN/OPEN/FIN).
  - Function crc32_step8 (8-bit next-state).
- Sub-module crc32_d16_step: purely combinational 16-bit next-state, with data_in[15:0] and crc_in[31:0] in and crc_out[31:0] out. The sequencer instantiates one and muxes in the 8-bit function result for odd tails.

Test Plan:
- Reset, then a single beat with sop=eop=1, in_bytes=2, data 16'h0201 -> exactly 1 RUN cycle; fcs_valid 2 cycles after accept; fcs_data matches the bit-serial golden model.
- 64-byte frame, 8 back-to-back beats, in_valid held high -> in_ready high only on final slices; fcs_valid exactly 33 cycles after the first accept; value matches the model.
- eop beat with in_bytes=3 -> 2 RUN cycles (16-bit then 8-bit); in_bytes=0 on eop -> 4 RUN cycles; both match the model.
- Beat without sop in IDLE -> err_sop pulses, no fcs_valid. sop received in OPEN mid-frame -> err_sop pulses, the new frame's FCS is correct. rst dropped during RUN -> all outputs 0 immediately, next frame correct.
- CRC_CHECK_EN: frame plus appended fcs_data (byte fcs_data[7:0] first) -> fcs_ok=1. Same frame with one data bit flipped -> fcs_ok=0.
